// File: rtl/alu_seq.sv
// alu_seq: registered, multi-cycle successor to the combinational 8-bit ALU.
//   Keeps the 4-bit alus op encoding and the x (accumulator) / bus operand roles,
//   and adds a start/busy/done handshake with registered result and flags.
//   Multiply (1011) and variable left shift (1100) iterate one bit per cycle.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   -> 1011 is an iterative shift-add multiply (WIDTH iterations)
//   undefined -> no multiplier; 1011 falls into the all-ones default op
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   op request, accepted only while busy=0
//   alus   in   [3:0] op select, sampled with start
//   x      in   [WIDTH-1:0] operand A (accumulator side)
//   bus    in   [WIDTH-1:0] operand B (bus side); bus[SHW-1:0] is the shift amount
//   busy   out  multi-cycle op in progress
//   done   out  one-cycle pulse, dout/flags just updated
//   dout   out  [WIDTH-1:0] registered result, held until next completion
//   flags  out  [3:0] {N,V,C,Z}, held until next completion
module alu_seq #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alus,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] bus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic [3:0]       flags
);

    // Counter is one bit wider than the shift field so it can hold WIDTH.
    localparam int unsigned CW = SHW + 1;
    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] dout_n;
    logic [3:0]       flags_n;
    logic             busy_n;
    logic             done_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [WIDTH-1:0] sh_q, sh_n;

`ifdef ALU_SEQ_MUL_EN
    logic             is_mul_q, is_mul_n;
    logic [PW-1:0]    mcand_q, mcand_n;
    logic [PW-1:0]    prod_q, prod_n, prod_step;
    logic [WIDTH-1:0] mplier_q, mplier_n;
`endif

    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             multi;

    logic             fin;
    logic [WIDTH-1:0] fin_res;
    logic             fin_c;
    logic             fin_v;

    assign amt   = bus[SHW-1:0];
    assign add_w = {1'b0, bus} + {1'b0, x};
    // The extra top bit of the difference is the borrow (bus < x).
    assign sub_w = {1'b0, bus} - {1'b0, x};

    // Single-cycle result/carry/overflow, plus detection of ops that need RUN.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        multi   = 1'b0;
        case (alus)
            4'b0000: alu_res = '0;
            4'b0001: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (bus[WIDTH-1] == x[WIDTH-1]) && (add_w[WIDTH-1] != x[WIDTH-1]);
            end
            4'b0010: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (bus[WIDTH-1] != x[WIDTH-1]) && (sub_w[WIDTH-1] != bus[WIDTH-1]);
            end
            4'b0011: alu_res = x & bus;
            4'b0100: alu_res = x | bus;
            4'b0101: alu_res = x ^ bus;
            4'b0110: begin
                alu_res = x + WIDTH'(1);
                alu_c   = (x == ALL_ONES);
                alu_v   = (x == ~MSB_ONLY);
            end
            4'b0111: begin
                alu_res = x - WIDTH'(1);
                alu_c   = (x == '0);
                alu_v   = (x == MSB_ONLY);
            end
            4'b1000: begin
                alu_res = x >> 1;
                alu_c   = x[0];
            end
            4'b1001: alu_res = bus;
            4'b1010: begin
                alu_res = -x;
                alu_v   = (x == MSB_ONLY);
            end
`ifdef ALU_SEQ_MUL_EN
            4'b1011: multi = 1'b1;
`endif
            // A zero shift amount completes immediately with x unchanged.
            4'b1100: begin
                alu_res = x;
                multi   = (amt != '0);
            end
            default: alu_res = ALL_ONES;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
`endif

    // Next-state, iteration and completion logic.
    always_comb begin
        state_n = state_q;
        dout_n  = dout;
        flags_n = flags;
        busy_n  = busy;
        done_n  = 1'b0;
        cnt_n   = cnt_q;
        sh_n    = sh_q;
        fin     = 1'b0;
        fin_res = '0;
        fin_c   = 1'b0;
        fin_v   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        is_mul_n = is_mul_q;
        mcand_n  = mcand_q;
        mplier_n = mplier_q;
        prod_n   = prod_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (multi) begin
                        state_n = RUN;
                        busy_n  = 1'b1;
                        sh_n    = x;
                        cnt_n   = CW'(amt);
`ifdef ALU_SEQ_MUL_EN
                        is_mul_n = (alus == 4'b1011);
                        mcand_n  = PW'(x);
                        mplier_n = bus;
                        prod_n   = '0;
                        if (alus == 4'b1011) begin
                            cnt_n = CW'(WIDTH);
                        end
`endif
                    end else begin
                        fin     = 1'b1;
                        fin_res = alu_res;
                        fin_c   = alu_c;
                        fin_v   = alu_v;
                    end
                end
            end
            RUN: begin
                cnt_n = cnt_q - CW'(1);
`ifdef ALU_SEQ_MUL_EN
                if (is_mul_q) begin
                    mcand_n  = mcand_q << 1;
                    mplier_n = mplier_q >> 1;
                    prod_n   = prod_step;
                    if (cnt_q == CW'(1)) begin
                        fin     = 1'b1;
                        fin_res = prod_step[WIDTH-1:0];
                        fin_c   = |prod_step[PW-1:WIDTH];
                        fin_v   = |prod_step[PW-1:WIDTH];
                    end
                end else
`endif
                begin
                    // The bit leaving the top on the final step is the carry.
                    sh_n = sh_q << 1;
                    if (cnt_q == CW'(1)) begin
                        fin     = 1'b1;
                        fin_res = sh_q << 1;
                        fin_c   = sh_q[WIDTH-1];
                    end
                end
                if (fin) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (fin) begin
            dout_n  = fin_res;
            flags_n = {fin_res[WIDTH-1], fin_v, fin_c, (fin_res == '0)};
            done_n  = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dout     <= '0;
            flags    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt_q    <= '0;
            sh_q     <= '0;
`ifdef ALU_SEQ_MUL_EN
            is_mul_q <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
`endif
        end else begin
            state_q  <= state_n;
            dout     <= dout_n;
            flags    <= flags_n;
            busy     <= busy_n;
            done     <= done_n;
            cnt_q    <= cnt_n;
            sh_q     <= sh_n;
`ifdef ALU_SEQ_MUL_EN
            is_mul_q <= is_mul_n;
            mcand_q  <= mcand_n;
            mplier_q <= mplier_n;
            prod_q   <= prod_n;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8). Expected results are pushed to a
// scoreboard queue when an op is issued and popped when done is seen.
module tb_alu_seq;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic [3:0]   f;
        int           lat;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   alus  = 4'h0;
    logic [W-1:0] x     = '0;
    logic [W-1:0] bus   = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic [3:0]   flags;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .alus  (alus),
        .x     (x),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .flags (flags)
    );

    function automatic exp_t mk(input logic [W-1:0] d, input logic [3:0] f, input int lat);
        exp_t e;
        e.d   = d;
        e.f   = f;
        e.lat = lat;
        return e;
    endfunction

    // Reference model written with integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        int           ua, ub, sa, sb, r, n;
        logic         c, v;
        logic [W-1:0] r8;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c = 1'b0;
        v = 1'b0;
        r = 0;
        e.lat = 1;
        case (op)
            4'h0: r = 0;
            4'h1: begin r = ub + ua; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'h2: begin r = ub - ua; c = (ub < ua); v = (sb - sa > 127) || (sb - sa < -128); end
            4'h3: r = int'(a & b);
            4'h4: r = int'(a | b);
            4'h5: r = int'(a ^ b);
            4'h6: begin r = ua + 1; c = (r > 255); v = (sa + 1 > 127); end
            4'h7: begin r = ua - 1; c = (ua < 1); v = (sa - 1 < -128); end
            4'h8: begin r = ua >> 1; c = a[0]; end
            4'h9: r = ub;
            4'hA: begin r = -ua; v = (ua == 128); end
`ifdef ALU_SEQ_MUL_EN
            4'hB: begin r = ua * ub; c = (r > 255); v = (r > 255); e.lat = 9; end
`endif
            4'hC: begin
                n = ub % 8;
                r = ua << n;
                c = (n != 0) && (((r >> 8) & 1) == 1);
                e.lat = n + 1;
            end
            default: r = 255;
        endcase
        r8  = 8'(r);
        e.d = r8;
        e.f = {r8[7], v, c, (r8 == 8'h00)};
        return e;
    endfunction

    task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        exp_q.push_back(e);
        start = 1'b1;
        alus  = op;
        x     = a;
        bus   = b;
    endtask

    // Waits (bounded) for done, dropping start after the accepting edge.
    task automatic wait_done();
        cyc      = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy === 1'b1) busy_cnt++;
        end while (done !== 1'b1 && cyc < 50);
    endtask

    task automatic test_reset();
        exp_t e;
        int   seen;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, dout, flags} !== '0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b dout=%h flags=%b expected all zero", busy, done, dout, flags);
        end
        rst = 1'b0;
        @(negedge clk);
        start_op(4'h1, 8'h10, 8'h20, mk(8'h30, 4'b0000, 1));
        wait_done();
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || dout !== e.d) begin
            failures++;
            $display("FAIL pre_abort_add done=%b dout=%h expected done=1 dout=%h", done, dout, e.d);
        end
`ifdef ALU_SEQ_MUL_EN
        start_op(4'hB, 8'd13, 8'd11, model(4'hB, 8'd13, 8'd11));
`else
        start_op(4'hC, 8'h81, 8'h07, model(4'hC, 8'h81, 8'h07));
`endif
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_before busy=%b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, dout, flags} !== '0) begin
            failures++;
            $display("FAIL abort_async busy=%b done=%b dout=%h flags=%b expected all zero", busy, done, dout, flags);
        end
        exp_q.delete();
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || dout !== '0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_quiet activity_cycles=%0d expected 0", seen);
        end
        start_op(4'h1, 8'h01, 8'hFF, mk(8'h00, 4'b0011, 1));
        wait_done();
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || cyc != e.lat) begin
            failures++;
            $display("FAIL post_reset_lat done=%b cycles=%0d expected done=1 cycles=%0d", done, cyc, e.lat);
        end
        checks++;
        if (dout !== e.d || flags !== e.f) begin
            failures++;
            $display("FAIL post_reset_add dout=%h flags=%b expected dout=%h flags=%b", dout, flags, e.d, e.f);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width done=%b expected 0", done);
        end
    endtask

    // Spec-listed vectors: {op, x, bus, dout, flags, latency}.
    task automatic test_vectors();
        logic [3:0]   vop[8];
        logic [W-1:0] va[8], vb[8], vd[8];
        logic [3:0]   vf[8];
        int           vl[8];
        int           nv;
        exp_t         e;
        nv = 0;
        vop[nv] = 4'h2; va[nv] = 8'h01; vb[nv] = 8'h80; vd[nv] = 8'h7F; vf[nv] = 4'b0100; vl[nv] = 1; nv++;
        vop[nv] = 4'hA; va[nv] = 8'h80; vb[nv] = 8'h00; vd[nv] = 8'h80; vf[nv] = 4'b1100; vl[nv] = 1; nv++;
        vop[nv] = 4'hC; va[nv] = 8'h81; vb[nv] = 8'h03; vd[nv] = 8'h08; vf[nv] = 4'b0000; vl[nv] = 4; nv++;
        vop[nv] = 4'hC; va[nv] = 8'h81; vb[nv] = 8'h00; vd[nv] = 8'h81; vf[nv] = 4'b1000; vl[nv] = 1; nv++;
        vop[nv] = 4'hC; va[nv] = 8'h03; vb[nv] = 8'h07; vd[nv] = 8'h80; vf[nv] = 4'b1010; vl[nv] = 8; nv++;
`ifdef ALU_SEQ_MUL_EN
        vop[nv] = 4'hB; va[nv] = 8'd13; vb[nv] = 8'd11; vd[nv] = 8'h8F; vf[nv] = 4'b1000; vl[nv] = 9; nv++;
        vop[nv] = 4'hB; va[nv] = 8'h10; vb[nv] = 8'h10; vd[nv] = 8'h00; vf[nv] = 4'b0111; vl[nv] = 9; nv++;
        vop[nv] = 4'hB; va[nv] = 8'hFF; vb[nv] = 8'hFF; vd[nv] = 8'h01; vf[nv] = 4'b0110; vl[nv] = 9; nv++;
`else
        vop[nv] = 4'hB; va[nv] = 8'h03; vb[nv] = 8'h05; vd[nv] = 8'hFF; vf[nv] = 4'b1000; vl[nv] = 1; nv++;
`endif
        for (int i = 0; i < nv; i++) begin
            start_op(vop[i], va[i], vb[i], mk(vd[i], vf[i], vl[i]));
            wait_done();
            e = exp_q.pop_front();
            checks++;
            if (done !== 1'b1 || cyc != e.lat) begin
                failures++;
                $display("FAIL vec%0d_latency op=%h done=%b cycles=%0d expected cycles=%0d", i, vop[i], done, cyc, e.lat);
            end
            checks++;
            if (busy_cnt != e.lat - 1) begin
                failures++;
                $display("FAIL vec%0d_busy op=%h busy_cycles=%0d expected %0d", i, vop[i], busy_cnt, e.lat - 1);
            end
            checks++;
            if (dout !== e.d || flags !== e.f) begin
                failures++;
                $display("FAIL vec%0d_result op=%h dout=%h flags=%b expected dout=%h flags=%b", i, vop[i], dout, flags, e.d, e.f);
            end
            @(negedge clk);
        end
    endtask

    // Random ops issued back-to-back against the model.
    task automatic test_random();
        logic [W-1:0] corner[4];
        logic [3:0]   op;
        logic [W-1:0] a, b;
        exp_t         e;
        corner[0] = 8'h00; corner[1] = 8'h7F; corner[2] = 8'h80; corner[3] = 8'hFF;
        for (int i = 0; i < 48; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
            start_op(op, a, b, model(op, a, b));
            wait_done();
            e = exp_q.pop_front();
            checks++;
            if (done !== 1'b1 || cyc != e.lat || busy_cnt != e.lat - 1) begin
                failures++;
                $display("FAIL rand%0d_timing op=%h done=%b cycles=%0d busy_cycles=%0d expected cycles=%0d", i, op, done, cyc, busy_cnt, e.lat);
            end
            checks++;
            if (dout !== e.d || flags !== e.f) begin
                failures++;
                $display("FAIL rand%0d_result op=%h x=%h bus=%h dout=%h flags=%b expected dout=%h flags=%b", i, op, a, b, dout, flags, e.d, e.f);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
`ifdef ALU_SEQ_MUL_EN
        start_op(4'hB, 8'd13, 8'd11, mk(8'h8F, 4'b1000, 9));
`else
        start_op(4'hC, 8'h81, 8'h07, mk(8'h80, 4'b1000, 8));
`endif
        // Hold start high with changing operands while the op runs.
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (done !== 1'b1) begin
                alus = 4'($urandom);
                x    = 8'($urandom);
                bus  = 8'($urandom);
            end
        end while (done !== 1'b1 && cyc < 50);
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || cyc != e.lat) begin
            failures++;
            $display("FAIL held_start_latency done=%b cycles=%0d expected %0d", done, cyc, e.lat);
        end
        checks++;
        if (dout !== e.d || flags !== e.f) begin
            failures++;
            $display("FAIL held_start_result dout=%h flags=%b expected dout=%h flags=%b", dout, flags, e.d, e.f);
        end
        start_op(4'h5, 8'h3C, 8'h0F, mk(8'h33, 4'b0000, 1));
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || dout !== e.d || flags !== e.f) begin
            failures++;
            $display("FAIL b2b_first done=%b dout=%h flags=%b expected done=1 dout=%h flags=%b", done, dout, flags, e.d, e.f);
        end
        start_op(4'h7, 8'h00, 8'h00, mk(8'hFF, 4'b1010, 1));
        @(negedge clk);
        start = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || dout !== e.d || flags !== e.f) begin
            failures++;
            $display("FAIL b2b_second done=%b dout=%h flags=%b expected done=1 dout=%h flags=%b", done, dout, flags, e.d, e.f);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || dout !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_idle done=%b dout=%h expected done=0 dout=ff", done, dout);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
